// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// N-channel debouncer for board push-buttons and power/mode switches. Each
// channel is fully independent: it has its own 2-flop synchroniser, its own
// stability counter, one-cycle press/release strobes and (optionally) an
// auto-repeat strobe generator for held buttons. A channel that is bouncing
// never delays or disturbs any other channel.
//
// Parameters
//   WIDTH          number of independent channels (>= 1)
//   STABLE_CYCLES  consecutive synchronised samples that must differ from the
//                  current debounced level before it flips (>= 1)
//   REPEAT_EN      1 builds the auto-repeat logic, 0 ties btn_repeat low
//   REPEAT_DELAY   cycles from a press strobe to the first repeat strobe (>= 1)
//   REPEAT_RATE    cycles between successive repeat strobes (>= 1)
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset, overrides everything
//   btn_raw      asynchronous raw pad levels, one bit per channel
//   btn_stable   debounced level per channel
//   btn_press    one-cycle strobe on a debounced 0->1 transition
//   btn_release  one-cycle strobe on a debounced 1->0 transition
//   btn_repeat   one-cycle auto-repeat strobe while a button is held
//   any_press    OR of btn_press, registered in the same cycle as btn_press
//
// Timing: a clean raw edge first sampled at rising edge t shows up on
// btn_stable (and on the matching strobe) after rising edge t+1+STABLE_CYCLES,
// i.e. 2+STABLE_CYCLES cycles after the cycle in which the pad changed.
// ---------------------------------------------------------------------------
module button_debouncer #(
    parameter int WIDTH         = 5,
    parameter int STABLE_CYCLES = 233334,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_RATE   = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_stable,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic [WIDTH-1:0] btn_repeat,
    output logic             any_press
);

    // Stability counter only ever reaches STABLE_CYCLES-1, so it cannot wrap.
    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SCW-1:0] STAB_LAST = SCW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RPT   = 2'd2
    } rpt_state_t;

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if (WIDTH < 1) begin : g_bad_width
        $error("button_debouncer: WIDTH must be >= 1 (got %0d)", WIDTH);
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("button_debouncer: STABLE_CYCLES must be >= 1 (got %0d)", STABLE_CYCLES);
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("button_debouncer: REPEAT_DELAY must be >= 1 (got %0d)", REPEAT_DELAY);
    end
    if (REPEAT_RATE < 1) begin : g_bad_rate
        $error("button_debouncer: REPEAT_RATE must be >= 1 (got %0d)", REPEAT_RATE);
    end

    // -----------------------------------------------------------------------
    // Two-flop synchroniser; only sync0 is allowed to feed the debounce logic
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync0 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync0 <= sync1;
        end
    end

    // Per-channel flip events, valid in the cycle before the new level shows.
    logic [WIDTH-1:0] rise_evt;
    logic [WIDTH-1:0] fall_evt;

    // any_press is registered from the same events as btn_press so the two
    // line up exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |rise_evt;
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel debounce and auto-repeat
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch

        logic [SCW-1:0] stab_cnt;
        logic [SCW-1:0] stab_cnt_nxt;
        logic           stable_q;
        logic           stable_nxt;
        logic           press_q;
        logic           release_q;
        logic           rise;
        logic           fall;

        // Any sample equal to the current level restarts the run, so only an
        // unbroken run of STABLE_CYCLES differing samples flips the level.
        always_comb begin
            stab_cnt_nxt = stab_cnt;
            stable_nxt   = stable_q;
            rise         = 1'b0;
            fall         = 1'b0;
            if (sync0[i] == stable_q) begin
                stab_cnt_nxt = '0;
            end else if (stab_cnt == STAB_LAST) begin
                stab_cnt_nxt = '0;
                stable_nxt   = sync0[i];
                rise         = sync0[i];
                fall         = ~sync0[i];
            end else begin
                stab_cnt_nxt = stab_cnt + SCW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stab_cnt  <= '0;
                stable_q  <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                stab_cnt  <= stab_cnt_nxt;
                stable_q  <= stable_nxt;
                press_q   <= rise;
                release_q <= fall;
            end
        end

        assign rise_evt[i]    = rise;
        assign fall_evt[i]    = fall;
        assign btn_stable[i]  = stable_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;

        if (REPEAT_EN != 0) begin : g_rpt

            localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
            localparam int HCW      = $clog2(HOLD_MAX + 1);
            localparam logic [HCW-1:0] DELAY_LAST = HCW'(REPEAT_DELAY - 1);
            localparam logic [HCW-1:0] RATE_LAST  = HCW'(REPEAT_RATE - 1);

            rpt_state_t     state_q;
            rpt_state_t     state_nxt;
            logic [HCW-1:0] hold_cnt;
            logic [HCW-1:0] hold_cnt_nxt;
            logic           rpt_q;
            logic           rpt_nxt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q  <= IDLE;
                    hold_cnt <= '0;
                    rpt_q    <= 1'b0;
                end else begin
                    state_q  <= state_nxt;
                    hold_cnt <= hold_cnt_nxt;
                    rpt_q    <= rpt_nxt;
                end
            end

            // hold_cnt holds the number of cycles since the last press or
            // repeat strobe; the strobe is registered, so it is raised when
            // the count is one short of the target. The falling event is
            // taken before it is registered so that the FSM is already idle
            // (and silent) in the cycle the release strobe appears.
            always_comb begin
                state_nxt    = state_q;
                hold_cnt_nxt = hold_cnt;
                rpt_nxt      = 1'b0;
                if (fall) begin
                    state_nxt    = IDLE;
                    hold_cnt_nxt = '0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (press_q) begin
                                if (DELAY_LAST == '0) begin
                                    // Delay of one: first repeat right after the press.
                                    rpt_nxt      = 1'b1;
                                    state_nxt    = RPT;
                                    hold_cnt_nxt = '0;
                                end else begin
                                    state_nxt    = DELAY;
                                    hold_cnt_nxt = HCW'(1);
                                end
                            end
                        end
                        DELAY: begin
                            if (hold_cnt == DELAY_LAST) begin
                                rpt_nxt      = 1'b1;
                                state_nxt    = RPT;
                                hold_cnt_nxt = '0;
                            end else begin
                                hold_cnt_nxt = hold_cnt + HCW'(1);
                            end
                        end
                        RPT: begin
                            if (hold_cnt == RATE_LAST) begin
                                rpt_nxt      = 1'b1;
                                hold_cnt_nxt = '0;
                            end else begin
                                hold_cnt_nxt = hold_cnt + HCW'(1);
                            end
                        end
                        default: begin
                            state_nxt    = IDLE;
                            hold_cnt_nxt = '0;
                        end
                    endcase
                end
            end

            assign btn_repeat[i] = rpt_q;

        end else begin : g_no_rpt
            assign btn_repeat[i] = 1'b0;
        end
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Parametrised N-channel debouncer for board push-buttons and power/mode switches; sits between the raw pad inputs and all control logic.
- Each channel has a 2-flop synchroniser, its own stability counter, one-cycle press/release strobes and an optional auto-repeat strobe for held buttons.
- Replaces the fixed 5-channel, shared-counter debouncer. Channels are independent, so a bouncing channel never delays another.

Parameters:
- WIDTH, 5, number of independent input channels (>=1).
- STABLE_CYCLES, 233334, consecutive synchronised samples that must differ from the current stable value before it flips (>=1).
- REPEAT_EN, 0, 1 enables auto-repeat strobes; 0 ties btn_repeat to 0.
- REPEAT_DELAY, 25000000, cycles from the press strobe to the first repeat strobe (>=1).
- REPEAT_RATE, 5000000, cycles between successive repeat strobes (>=1).

Ports:
- clk, input, 1, system clock; all logic on posedge.
- rst, input, 1, synchronous active-high reset.
- btn_raw, input, WIDTH, asynchronous raw button/switch levels.
- btn_stable, output, WIDTH, debounced level per channel.
- btn_press, output, WIDTH, one-cycle strobe on a debounced 0->1 transition.
- btn_release, output, WIDTH, one-cycle strobe on a debounced 1->0 transition.
- btn_repeat, output, WIDTH, one-cycle auto-repeat strobe while held (0 if REPEAT_EN=0).
- any_press, output, 1, OR-reduction of btn_press (registered with it, same cycle).

Behaviour:
- Reset: synchroniser flops, btn_stable, btn_press, btn_release, btn_repeat, any_press, all counters = 0; repeat FSM = IDLE. Reset overrides every other event in the same cycle.
- Synchroniser: sync1 <= btn_raw; sync0 <= sync1. Only sync0 feeds the debounce logic.
- Stability counter, per channel, width $clog2(STABLE_CYCLES+1):
  - If sync0 == btn_stable, the counter clears to 0.
  - Otherwise, if counter == STABLE_CYCLES-1: btn_stable flips, counter clears, and the matching strobe (press or release) asserts in the same cycle the new level first appears.
  - Otherwise the counter increments.
  - Any sample equal to btn_stable restarts the count, so a glitch shorter than STABLE_CYCLES produces no output.
- Latency: a clean btn_raw edge sampled at cycle t gives btn_stable changed at cycle t+2+STABLE_CYCLES, with the strobe high in that cycle only.
- Strobes: btn_press and btn_release are one cycle wide. For a given channel they are never high in the same cycle.
- Repeat FSM, per channel, states IDLE / DELAY / RPT, hold counter width $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1):
  - IDLE -> DELAY on the press strobe; the counter loads 1 in the cycle after the strobe.
  - DELAY: counter increments each cycle. When counter == REPEAT_DELAY, assert btn_repeat, clear the counter, go to RPT. First repeat lands exactly REPEAT_DELAY cycles after the press strobe.
  - RPT: assert btn_repeat every REPEAT_RATE cycles.
  - Any state -> IDLE with the counter cleared in the cycle btn_stable falls (same cycle as btn_release). No repeat strobe in that cycle.
  - REPEAT_EN=0: FSM and hold counters are not generated; btn_repeat = 0 constantly.
- Channel independence: no counter or state is shared. Simultaneous edges on several channels produce simultaneous strobes.
- Width rules: counters saturate by construction, with no wrap. Compares use full counter width. Parameters are checked by elaboration-time assertion: STABLE_CYCLES, REPEAT_DELAY and REPEAT_RATE must each be >=1.
- Reset mid-operation: an in-progress count or repeat is abandoned and btn_stable returns to 0. After rst deasserts, a held button takes the full 2+STABLE_CYCLES to re-assert, then emits a fresh press strobe.

Test Plan (WIDTH=5, STABLE_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_RATE=3):
- Clean press: btn_raw[0] 0->1 at cycle 10 and held -> btn_stable[0]=1 and btn_press[0]=any_press=1 at cycle 16 only; other channels stay 0.
- Bounce rejection: btn_raw[1] toggles 1,0,1,1,1,0 every cycle, then holds 1 -> btn_stable[1] rises exactly 2+4 cycles after the final 0->1; exactly one btn_press[1] pulse.
- Auto-repeat: hold btn_raw[2] with the press strobe at cycle P -> btn_repeat[2] at P+10, P+13, P+16, ...; release -> btn_release[2] pulse, no further repeats, FSM back in IDLE.
- Release strobe: drop btn_raw[0] at cycle 40 -> btn_stable[0]=0 and btn_release[0]=1 at cycle 46; btn_press[0] stays 0.
- Simultaneous channels: btn_raw=5'b11111 at one cycle -> all five btn_press bits pulse in the same cycle; any_press is a single one-cycle pulse.
- Reset mid-count: rst=1 for 1 cycle while btn_raw[3] has been high 3 samples -> all outputs 0 next cycle; btn_stable[3] rises 6 cycles after rst deasserts, with a press pulse.
